// File: rtl/lfsr_pkg.sv
// Shared MMIO map and register bit positions for the LFSR block family.
package lfsr_pkg;

  // Existing LFSR stage registers and the sample-FIFO registers.
  localparam logic [15:0] POLY_ADDR      = 16'h0010;
  localparam logic [15:0] SEED_ADDR      = 16'h0012;
  localparam logic [15:0] CTRL_ADDR      = 16'h0014;
  localparam logic [15:0] DECIM_ADDR     = 16'h0016;
  localparam logic [15:0] FIFO_DATA_ADDR = 16'h0018;
  localparam logic [15:0] STATUS_ADDR    = 16'h001A;
  localparam logic [15:0] CLEAR_ADDR     = 16'h001C;

  // STATUS fields follow the count field, so positions are offsets from AW.
  localparam int ST_COUNT_LSB = 0;
  localparam int ST_EMPTY_OFS = 1;
  localparam int ST_FULL_OFS  = 2;
  localparam int ST_OVF_OFS   = 3;
  localparam int ST_UDF_OFS   = 4;

  // CLEAR write-data bits.
  localparam int CLR_FLUSH_BIT = 0;
  localparam int CLR_OVF_BIT   = 1;
  localparam int CLR_UDF_BIT   = 2;

endpackage

// File: rtl/lfsr_sample_fifo_if.sv
// Sample input, MMIO bus and FIFO status signals of the sample FIFO.
interface lfsr_sample_fifo_if #(
  parameter int n     = 8,
  parameter int DEPTH = 16
);
  localparam int AW = $clog2(DEPTH);

  logic [n-1:0]  q_in;
  logic          q_valid;
  logic          W;
  logic          R;
  logic [15:0]   A;
  logic [n-1:0]  D;
  logic [n-1:0]  rd_data;
  logic          rd_valid;
  logic          empty;
  logic          full;
  logic [AW:0]   count;

  modport master (
    output q_in, q_valid, W, R, A, D,
    input  rd_data, rd_valid, empty, full, count
  );

  modport slave (
    input  q_in, q_valid, W, R, A, D,
    output rd_data, rd_valid, empty, full, count
  );
endinterface

// File: rtl/sync_fifo.sv
// Synchronous FIFO; occupancy is tracked by a counter so full/empty never
// depend on pointer comparison. Flush beats push and pop.
module sync_fifo #(
  parameter int n     = 8,
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [n-1:0]  wdata,
  output logic [n-1:0]  rdata,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty
);
  localparam logic [AW:0] FULL_CNT = CW'(DEPTH);

  logic [n-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic          push_ok, pop_ok;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  // A pop in the same cycle frees the slot the push needs.
  assign pop_ok  = pop  && !flush && !empty;
  assign push_ok = push && !flush && (!full || pop_ok);
  assign rdata   = mem[rptr];

  // Storage write; the entry is visible to a pop on the following cycle.
  always_ff @(posedge clock)
    if (push_ok) mem[wptr] <= wdata;

  // Pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push_ok) wptr <= wptr + AW'(1);
      if (pop_ok)  rptr <= rptr + AW'(1);
      count <= count + CW'(push_ok) - CW'(pop_ok);
    end
endmodule

// File: rtl/lfsr_sample_fifo.sv
// Decimating sampler of the LFSR output feeding a FIFO, drained over MMIO.
module lfsr_sample_fifo
  import lfsr_pkg::*;
#(
  parameter int n     = 8,
  parameter int DEPTH = 16
) (
  input logic               clock,
  input logic               reset,
  lfsr_sample_fifo_if.slave bus
);
  localparam int AW      = $clog2(DEPTH);
  localparam bit UDF_VIS = (AW + ST_UDF_OFS) < n;
  localparam int UDF_IDX = UDF_VIS ? AW + ST_UDF_OFS : 0;

  logic [n-1:0]  decim, dcnt;
  logic          overflow, underflow;
  logic          wr, rd, dec_wr, clr_wr, flush;
  logic          accept, pop_req, pop_hit, ovf_set, udf_set;
  logic [n-1:0]  f_rdata, status, rd_mux;
  logic [AW:0]   f_count;
  logic          f_full, f_empty;

  // A simultaneous write wins; the read strobe is dropped.
  assign wr      = bus.W;
  assign rd      = bus.R && !bus.W;
  assign dec_wr  = wr && (bus.A == DECIM_ADDR);
  assign clr_wr  = wr && (bus.A == CLEAR_ADDR);
  assign flush   = clr_wr && bus.D[CLR_FLUSH_BIT];
  assign accept  = bus.q_valid && (dcnt == '0);
  assign pop_req = rd && (bus.A == FIFO_DATA_ADDR);
  assign pop_hit = pop_req && !flush && !f_empty;
  assign ovf_set = accept && !flush && f_full && !pop_hit;
  assign udf_set = pop_req && !flush && f_empty;

  sync_fifo #(.n(n), .DEPTH(DEPTH)) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (accept),
    .pop   (pop_req),
    .flush (flush),
    .wdata (bus.q_in),
    .rdata (f_rdata),
    .count (f_count),
    .full  (f_full),
    .empty (f_empty)
  );

  // Decimation: keep one of every decim+1 valid samples; a DECIM write
  // rearms so the next valid sample is taken.
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      decim <= '0;
      dcnt  <= '0;
    end else if (dec_wr) begin
      decim <= bus.D;
      dcnt  <= '0;
    end else if (bus.q_valid) begin
      dcnt  <= (dcnt == '0) ? decim : dcnt - n'(1);
    end

  // Sticky error flags; a new event in the clearing cycle stays set.
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= (overflow  && !(clr_wr && bus.D[CLR_OVF_BIT])) || ovf_set;
      underflow <= (underflow && !(clr_wr && bus.D[CLR_UDF_BIT])) || udf_set;
    end

  // STATUS word assembly.
  always_comb begin
    status                   = '0;
    status[AW:ST_COUNT_LSB]  = f_count;
    status[AW + ST_EMPTY_OFS] = f_empty;
    status[AW + ST_FULL_OFS]  = f_full;
    status[AW + ST_OVF_OFS]   = overflow;
    if (UDF_VIS) status[UDF_IDX] = underflow;
  end

  // Read-data select; empty or flushed pops and unmapped reads return 0.
  always_comb begin
    rd_mux = '0;
    case (bus.A)
      DECIM_ADDR:     rd_mux = decim;
      FIFO_DATA_ADDR: rd_mux = pop_hit ? f_rdata : '0;
      STATUS_ADDR:    rd_mux = status;
      default:        rd_mux = '0;
    endcase
  end

  // Registered read response, one cycle after the strobe.
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      bus.rd_data  <= '0;
      bus.rd_valid <= 1'b0;
    end else begin
      bus.rd_valid <= rd;
      if (rd) bus.rd_data <= rd_mux;
    end

  assign bus.count = f_count;
  assign bus.full  = f_full;
  assign bus.empty = f_empty;
endmodule

// File: tb/tb_lfsr_sample_fifo.sv
// Self-checking bench for lfsr_sample_fifo against a queue-based model.
module tb_lfsr_sample_fifo;
  import lfsr_pkg::*;

  localparam int N     = 8;
  localparam int DEPTH = 16;
  localparam int AW    = $clog2(DEPTH);

  logic clock, reset;
  int   checks, errors;

  lfsr_sample_fifo_if #(.n(N), .DEPTH(DEPTH)) bus ();

  lfsr_sample_fifo #(.n(N), .DEPTH(DEPTH)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference model state.
  logic [N-1:0] mq[$];
  int           mdecim, vidx;
  bit           movf, mudf;
  bit           exp_valid;
  logic [N-1:0] exp_data;

  function automatic logic [N-1:0] m_status();
    int s;
    s = mq.size();
    if (mq.size() == 0)     s |= 1 << (AW + 1);
    if (mq.size() == DEPTH) s |= 1 << (AW + 2);
    if (movf)               s |= 1 << (AW + 3);
    if (AW + 4 < N && mudf) s |= 1 << (AW + 4);
    return N'(s);
  endfunction

  task automatic model_reset();
    mq.delete();
    mdecim = 0; vidx = 0; movf = 0; mudf = 0;
    exp_valid = 0; exp_data = '0;
  endtask

  // One clock: update model from the inputs, apply them, return #1 after edge.
  task automatic step(input bit qv, input logic [N-1:0] qd, input bit w, input bit r,
                      input logic [15:0] a, input logic [N-1:0] d);
    bit rd_en, flush, acc, popped, ovf_s, udf_s;
    rd_en  = r && !w;
    flush  = w && a == CLEAR_ADDR && d[0];
    acc    = qv && (vidx % (mdecim + 1) == 0);
    exp_valid = rd_en;
    if (rd_en) begin
      if (a == DECIM_ADDR)                                   exp_data = N'(mdecim);
      else if (a == STATUS_ADDR)                             exp_data = m_status();
      else if (a == FIFO_DATA_ADDR && !flush && mq.size() > 0) exp_data = mq[0];
      else                                                   exp_data = '0;
    end
    popped = rd_en && a == FIFO_DATA_ADDR && !flush && mq.size() > 0;
    udf_s  = rd_en && a == FIFO_DATA_ADDR && !flush && mq.size() == 0;
    ovf_s  = acc && !flush && mq.size() == DEPTH && !popped;
    if (flush) mq.delete();
    else begin
      if (popped) void'(mq.pop_front());
      if (acc && !ovf_s) mq.push_back(qd);
    end
    if (w && a == CLEAR_ADDR) begin
      if (d[1]) movf = 0;
      if (d[2]) mudf = 0;
    end
    movf |= ovf_s;
    mudf |= udf_s;
    if (qv) vidx++;
    if (w && a == DECIM_ADDR) begin mdecim = int'(d); vidx = 0; end
    bus.q_valid = qv; bus.q_in = qd; bus.W = w; bus.R = r; bus.A = a; bus.D = d;
    @(posedge clock);
    #1;
    bus.q_valid = 0; bus.W = 0; bus.R = 0;
  endtask

  task automatic push(input logic [N-1:0] v);   step(1, v, 0, 0, 16'h0, '0); endtask
  task automatic rdreg(input logic [15:0] a);   step(0, '0, 0, 1, a, '0);    endtask
  task automatic wrreg(input logic [15:0] a, input logic [N-1:0] d); step(0, '0, 1, 0, a, d); endtask

  task automatic test_reset();
    #12;
    checks++; if (bus.count !== 0 || bus.empty !== 1 || bus.full !== 0) begin errors++;
      $display("FAIL reset_flags count=%0d empty=%0b full=%0b want 0/1/0", bus.count, bus.empty, bus.full); end
    checks++; if (bus.rd_valid !== 0 || bus.rd_data !== 0) begin errors++;
      $display("FAIL reset_rd rd_valid=%0b rd_data=%0h want 0/0", bus.rd_valid, bus.rd_data); end
    reset = 1;
    for (int i = 0; i < 5; i++) push(N'($urandom));
    rdreg(STATUS_ADDR);
    checks++; if (bus.rd_valid !== 1 || bus.rd_data !== exp_data || bus.rd_data !== 8'h05) begin errors++;
      $display("FAIL status_5 rd_valid=%0b rd_data=%0h want 1/05", bus.rd_valid, bus.rd_data); end
    #3 reset = 0;
    #1;
    model_reset();
    checks++; if (bus.count !== 0 || bus.empty !== 1 || bus.rd_valid !== 0) begin errors++;
      $display("FAIL async_reset count=%0d empty=%0b rd_valid=%0b want 0/1/0", bus.count, bus.empty, bus.rd_valid); end
    #1 reset = 1;
    rdreg(STATUS_ADDR);
    checks++; if (bus.rd_data !== 8'h20 || bus.rd_data !== exp_data) begin errors++;
      $display("FAIL status_after_reset got=%0h want 20", bus.rd_data); end
  endtask

  task automatic test_decim();
    logic [N-1:0] want [3];
    want[0] = 1; want[1] = 4; want[2] = 7;
    wrreg(DECIM_ADDR, 2);
    for (int i = 1; i <= 9; i++) push(N'(i));
    checks++; if (bus.count !== 3) begin errors++;
      $display("FAIL decim_count got=%0d want 3", bus.count); end
    rdreg(DECIM_ADDR);
    checks++; if (bus.rd_data !== 2) begin errors++;
      $display("FAIL decim_readback got=%0d want 2", bus.rd_data); end
    for (int i = 0; i < 3; i++) begin
      rdreg(FIFO_DATA_ADDR);
      checks++; if (bus.rd_valid !== 1 || bus.rd_data !== want[i] || bus.rd_data !== exp_data) begin errors++;
        $display("FAIL decim_pop%0d rd_valid=%0b got=%0d want %0d", i, bus.rd_valid, bus.rd_data, want[i]); end
    end
    step(0, '0, 0, 0, 16'h0, '0);
    checks++; if (bus.rd_valid !== 0 || bus.count !== 0 || bus.empty !== 1) begin errors++;
      $display("FAIL decim_after rd_valid=%0b count=%0d want 0/0", bus.rd_valid, bus.count); end
  endtask

  task automatic test_overflow();
    logic [N-1:0] first;
    wrreg(DECIM_ADDR, 0);
    first = N'($urandom);
    push(first);
    for (int i = 1; i < DEPTH + 2; i++) push(N'($urandom));
    checks++; if (bus.count !== DEPTH || bus.full !== 1) begin errors++;
      $display("FAIL ovf_full count=%0d full=%0b want 16/1", bus.count, bus.full); end
    rdreg(STATUS_ADDR);
    checks++; if (bus.rd_data[AW+3] !== 1'b1 || bus.rd_data !== exp_data) begin errors++;
      $display("FAIL ovf_status got=%0h want %0h", bus.rd_data, exp_data); end
    rdreg(FIFO_DATA_ADDR);
    checks++; if (bus.rd_data !== first) begin errors++;
      $display("FAIL ovf_first_pop got=%0h want %0h", bus.rd_data, first); end
    wrreg(CLEAR_ADDR, 8'h02);
    rdreg(STATUS_ADDR);
    checks++; if (bus.rd_data[AW+3] !== 1'b0 || bus.rd_data !== exp_data) begin errors++;
      $display("FAIL ovf_clear got=%0h want %0h", bus.rd_data, exp_data); end
  endtask

  task automatic test_full_pushpop();
    logic [N-1:0] newest, oldest;
    push(N'($urandom));
    checks++; if (bus.full !== 1) begin errors++;
      $display("FAIL fpp_full full=%0b want 1", bus.full); end
    oldest = mq[0];
    newest = N'($urandom);
    step(1, newest, 0, 1, FIFO_DATA_ADDR, '0);
    checks++; if (bus.rd_data !== oldest || bus.count !== DEPTH) begin errors++;
      $display("FAIL fpp_pop got=%0h count=%0d want %0h/16", bus.rd_data, bus.count, oldest); end
    rdreg(STATUS_ADDR);
    checks++; if (bus.rd_data[AW+3] !== 1'b0) begin errors++;
      $display("FAIL fpp_no_ovf status=%0h", bus.rd_data); end
    for (int i = 0; i < DEPTH; i++) begin
      rdreg(FIFO_DATA_ADDR);
      checks++; if (bus.rd_data !== exp_data) begin errors++;
        $display("FAIL fpp_drain%0d got=%0h want %0h", i, bus.rd_data, exp_data); end
    end
    checks++; if (bus.rd_data !== newest || bus.empty !== 1) begin errors++;
      $display("FAIL fpp_tail got=%0h want %0h", bus.rd_data, newest); end
  endtask

  task automatic test_underflow();
    logic [N-1:0] v;
    rdreg(FIFO_DATA_ADDR);
    checks++; if (bus.rd_data !== 0 || bus.rd_valid !== 1 || dut.underflow !== 1 || bus.count !== 0) begin errors++;
      $display("FAIL udf_empty rd=%0h vld=%0b udf=%0b count=%0d want 0/1/1/0", bus.rd_data, bus.rd_valid, dut.underflow, bus.count); end
    wrreg(CLEAR_ADDR, 8'h04);
    checks++; if (dut.underflow !== 0) begin errors++;
      $display("FAIL udf_clear udf=%0b want 0", dut.underflow); end
    v = N'($urandom);
    step(1, v, 0, 1, FIFO_DATA_ADDR, '0);
    checks++; if (bus.rd_data !== 0 || dut.underflow !== 1 || bus.count !== 1) begin errors++;
      $display("FAIL udf_pushpop rd=%0h udf=%0b count=%0d want 0/1/1", bus.rd_data, dut.underflow, bus.count); end
    rdreg(FIFO_DATA_ADDR);
    checks++; if (bus.rd_data !== v) begin errors++;
      $display("FAIL udf_follow got=%0h want %0h", bus.rd_data, v); end
  endtask

  task automatic test_flush();
    logic [N-1:0] v;
    for (int i = 0; i < 3; i++) push(N'($urandom));
    step(1, N'($urandom), 1, 0, CLEAR_ADDR, 8'h01);
    checks++; if (bus.count !== 0 || bus.empty !== 1 || dut.underflow !== 1) begin errors++;
      $display("FAIL flush count=%0d empty=%0b udf=%0b want 0/1/1", bus.count, bus.empty, dut.underflow); end
    rdreg(STATUS_ADDR);
    checks++; if (bus.rd_data !== exp_data || bus.rd_data[AW+3] !== 1'b0) begin errors++;
      $display("FAIL flush_status got=%0h want %0h", bus.rd_data, exp_data); end
    v = N'($urandom);
    push(v);
    rdreg(FIFO_DATA_ADDR);
    checks++; if (bus.rd_data !== v) begin errors++;
      $display("FAIL flush_next got=%0h want %0h", bus.rd_data, v); end
  endtask

  task automatic test_random();
    logic [15:0] a;
    logic [N-1:0] d;
    bit w, r, qv;
    int op;
    for (int c = 0; c < 600; c++) begin
      qv = ($urandom_range(0, 9) < 6);
      w = 0; r = 0; a = FIFO_DATA_ADDR; d = '0;
      op = $urandom_range(0, 11);
      case (op)
        0, 1, 2, 3: r = 1;
        4: begin r = 1; a = STATUS_ADDR; end
        5: begin r = 1; a = DECIM_ADDR; end
        6: begin w = 1; a = DECIM_ADDR; d = N'($urandom_range(0, 3)); end
        7: begin w = 1; a = CLEAR_ADDR; d = N'($urandom_range(0, 7));
             if ($urandom_range(0, 3) != 0) d[0] = 1'b0; end
        8: begin r = 1; a = POLY_ADDR; end
        9: begin w = 1; r = 1; a = DECIM_ADDR; d = N'($urandom_range(0, 3)); end
        default: ;
      endcase
      step(qv, N'($urandom), w, r, a, d);
      checks++; if (bus.rd_valid !== exp_valid || bus.rd_data !== exp_data) begin errors++;
        $display("FAIL rand_rd c=%0d vld=%0b data=%0h want %0b/%0h", c, bus.rd_valid, bus.rd_data, exp_valid, exp_data); end
      checks++; if (bus.count !== mq.size() || bus.empty !== (mq.size() == 0) || bus.full !== (mq.size() == DEPTH)) begin errors++;
        $display("FAIL rand_occ c=%0d count=%0d want %0d", c, bus.count, mq.size()); end
      checks++; if (dut.underflow !== mudf) begin errors++;
        $display("FAIL rand_udf c=%0d udf=%0b want %0b", c, dut.underflow, mudf); end
    end
  endtask

  initial begin
    checks = 0; errors = 0;
    reset = 0;
    bus.q_valid = 0; bus.q_in = '0; bus.W = 0; bus.R = 0; bus.A = '0; bus.D = '0;
    model_reset();
    test_reset();
    test_decim();
    test_overflow();
    test_full_pushpop();
    test_underflow();
    test_flush();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
